// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg
// Shared types and default sizing for the instruction fetch queue.
//   INST_PACKET          - one fetched instruction (valid flag, pc, raw encoding)
//   DEFAULT_DEPTH        - default number of queue entries
//   DEFAULT_N            - default dispatch width
//   DEFAULT_FETCH_WIDTH  - default number of fetch lanes per cycle
package inst_fetch_queue_pkg;

    localparam int DEFAULT_DEPTH       = 8;
    localparam int DEFAULT_N           = 2;
    localparam int DEFAULT_FETCH_WIDTH = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } INST_PACKET;

endpackage

// File: rtl/queue_idx_wrap.sv
// queue_idx_wrap
// Combinational modulo-DEPTH adder for circular-buffer indices.
// DEPTH need not be a power of two, so the wrap is an explicit compare and
// subtract rather than bit truncation.
//   base   in  current index, always < DEPTH
//   offset in  amount to advance, at most DEPTH (one bit wider than base)
//   idx    out (base + offset) wrapped into 0..DEPTH-1
module queue_idx_wrap #(
    parameter int DEPTH = 8
) (
    input  logic [$clog2(DEPTH)-1:0] base,
    input  logic [$clog2(DEPTH):0]   offset,
    output logic [$clog2(DEPTH)-1:0] idx
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] sum;

    // base <= DEPTH-1 and offset <= DEPTH keep the sum below 2*DEPTH,
    // so a single conditional subtraction always lands back in range.
    assign sum = {1'b0, base} + offset;
    assign idx = (sum >= (PW+1)'(DEPTH)) ? PW'(sum - (PW+1)'(DEPTH)) : PW'(sum);

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
// Circular instruction queue between fetch and dispatch. Fetch presents up to
// FETCH_WIDTH instructions per cycle and is told how many were taken; dispatch
// sees the oldest min(count, N) entries combinationally and requests how many
// to consume. Accept and dispatch counts are clamped internally so the queue
// can neither overflow nor underflow. br_en squashes everything.
//   clock, reset      clock and synchronous active-high reset
//   in_insts          fetch lanes, lanes 0..in_count-1 valid
//   in_count          number of valid fetch lanes
//   dispatch_req      entries dispatch wants this cycle
//   br_en             mispredict squash, empties the queue on the next edge
//   dispatched_insts  oldest entries, lanes >= num_avail forced to zero
//   num_avail         entries offered to dispatch (0 during br_en)
//   num_accepted      fetch lanes written this cycle
//   count/full/empty  registered occupancy status
//   debug_*           raw storage and pointers for observation
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter  int DEPTH       = DEFAULT_DEPTH,
    parameter  int N           = DEFAULT_N,
    parameter  int FETCH_WIDTH = DEFAULT_FETCH_WIDTH,
    localparam int PW          = $clog2(DEPTH),
    localparam int CW          = $clog2(DEPTH + 1),
    localparam int NW          = $clog2(N + 1),
    localparam int IW          = $clog2(FETCH_WIDTH + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  INST_PACKET [FETCH_WIDTH-1:0]  in_insts,
    input  logic [IW-1:0]                 in_count,
    input  logic [NW-1:0]                 dispatch_req,
    input  logic                          br_en,
    output INST_PACKET [N-1:0]            dispatched_insts,
    output logic [NW-1:0]                 num_avail,
    output logic [IW-1:0]                 num_accepted,
    output logic [CW-1:0]                 count,
    output logic                          full,
    output logic                          empty,
    output INST_PACKET [DEPTH-1:0]        debug_entries,
    output logic [PW-1:0]                 debug_head,
    output logic [PW-1:0]                 debug_tail
);

    INST_PACKET [DEPTH-1:0] entries;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [PW:0]            count_r;

    logic [PW-1:0]          next_head;
    logic [PW-1:0]          next_tail;
    logic [PW:0]            avail_full;
    logic [PW:0]            free_slots;
    logic [NW-1:0]          num_disp;
    logic [PW-1:0]          rd_idx [N];
    logic [PW-1:0]          wr_idx [FETCH_WIDTH];

    // Per-lane physical indices for the dispatch window and the fetch write window.
    for (genvar i = 0; i < N; i++) begin : g_rd_idx
        queue_idx_wrap #(.DEPTH(DEPTH)) u_rd_wrap (
            .base   (head),
            .offset ((PW+1)'(i)),
            .idx    (rd_idx[i])
        );
    end

    for (genvar j = 0; j < FETCH_WIDTH; j++) begin : g_wr_idx
        queue_idx_wrap #(.DEPTH(DEPTH)) u_wr_wrap (
            .base   (tail),
            .offset ((PW+1)'(j)),
            .idx    (wr_idx[j])
        );
    end

    queue_idx_wrap #(.DEPTH(DEPTH)) u_head_wrap (
        .base   (head),
        .offset ((PW+1)'(num_disp)),
        .idx    (next_head)
    );

    queue_idx_wrap #(.DEPTH(DEPTH)) u_tail_wrap (
        .base   (tail),
        .offset ((PW+1)'(num_accepted)),
        .idx    (next_tail)
    );

    // Clamp dispatch to what is present and fetch to what fits. Slots freed by
    // this cycle's dispatch count as free, so a full queue can still take
    // instructions while it drains.
    always_comb begin
        avail_full = (count_r > (PW+1)'(N)) ? (PW+1)'(N) : count_r;
        num_avail  = br_en ? '0 : NW'(avail_full);
        num_disp   = (dispatch_req < num_avail) ? dispatch_req : num_avail;
        free_slots = (PW+1)'(DEPTH) - count_r + (PW+1)'(num_disp);
        if (br_en) begin
            num_accepted = '0;
        end else if ((PW+1)'(in_count) < free_slots) begin
            num_accepted = in_count;
        end else begin
            num_accepted = IW'(free_slots);
        end
    end

    // Lanes beyond num_avail are zeroed so dispatch never sees stale data.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            dispatched_insts[i] = (NW'(i) < num_avail) ? entries[rd_idx[i]] : '0;
        end
    end

    // Consumed slots are cleared before the fetch writes, so a slot that is
    // freed and refilled in the same cycle ends up holding the new instruction.
    always_ff @(posedge clock) begin
        if (reset || br_en) begin
            entries <= '0;
            head    <= '0;
            tail    <= '0;
            count_r <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (NW'(i) < num_disp) begin
                    entries[rd_idx[i]] <= '0;
                end
            end
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (IW'(j) < num_accepted) begin
                    entries[wr_idx[j]] <= in_insts[j];
                end
            end
            head    <= next_head;
            tail    <= next_tail;
            count_r <= count_r - (PW+1)'(num_disp) + (PW+1)'(num_accepted);
        end
    end

    assign count         = CW'(count_r);
    assign full          = (count_r == (PW+1)'(DEPTH));
    assign empty         = (count_r == '0);
    assign debug_entries = entries;
    assign debug_head    = head;
    assign debug_tail    = tail;

endmodule
